// File: rtl/sprite_palette_ram.sv
// ---------------------------------------------------------------------------
// sprite_palette_ram
//
// Runtime-writable, multi-bank colour palette for the HDMI piece renderer.
// Holds NUM_PALETTES banks of 2^INDEX_W RGB entries in one RAM, cleared to
// KEY_RGB after every reset. Each pixel lookup is a 2-stage pipeline:
//   stage 1 : synchronous RAM read + registered valid / highlight / range flag
//   stage 2 : colour-key detection, optional highlight tint, output registers
// A host-side write port reloads colours once the clear sequence has finished.
//
// Ports
//   clk          pixel clock, all state on the rising edge
//   resetn       asynchronous active-low reset
//   pix_valid_i  lookup request this cycle
//   pix_pal_i    bank select for the lookup
//   pix_index_i  palette index for the lookup
//   pix_hl_i     apply the highlight tint to this pixel
//   pix_valid_o  output pixel valid (only qualifier of the colour outputs)
//   red/green/blue resolved colour channels
//   pix_transp_o pixel is transparent (colour key hit or bank out of range)
//   wr_valid     host write request
//   wr_ready     host write accepted when wr_valid && wr_ready
//   wr_pal       target bank of the write
//   wr_index     target entry of the write
//   wr_rgb       colour to store, packed {r,g,b}
//   init_done    high once the post-reset memory clear has completed
// ---------------------------------------------------------------------------
module sprite_palette_ram #(
    parameter int                 INDEX_W      = 4,
    parameter int                 NUM_PALETTES = 12,
    parameter int                 COLOR_W      = 4,
    parameter logic [3*COLOR_W-1:0] KEY_RGB    = 12'hF0F,
    parameter logic [3*COLOR_W-1:0] HL_RGB     = 12'h0F0,
    parameter int                 PAL_W        = $clog2(NUM_PALETTES)
) (
    input  logic                 clk,
    input  logic                 resetn,

    // pixel lookup
    input  logic                 pix_valid_i,
    input  logic [PAL_W-1:0]     pix_pal_i,
    input  logic [INDEX_W-1:0]   pix_index_i,
    input  logic                 pix_hl_i,
    output logic                 pix_valid_o,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 pix_transp_o,

    // host write port
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [PAL_W-1:0]     wr_pal,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3*COLOR_W-1:0] wr_rgb,

    output logic                 init_done
);

    localparam int RGB_W      = 3 * COLOR_W;
    localparam int BANK_DEPTH = 1 << INDEX_W;
    localparam int DEPTH      = NUM_PALETTES * BANK_DEPTH;
    // {pal, index} is exactly pal * 2^INDEX_W + index.
    localparam int ADDR_W     = PAL_W + INDEX_W;

    localparam logic [PAL_W:0]    PAL_LIMIT = (PAL_W + 1)'(NUM_PALETTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // -----------------------------------------------------------------------
    // Control FSM: clear every word to the colour key, then run forever.
    // -----------------------------------------------------------------------
    state_t            state;
    logic [ADDR_W-1:0] init_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_cnt  <= '0;
                        wr_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Only reset leaves RUN.
                    state <= ST_RUN;
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM write port: the init sweep owns the port during INIT, the host
    // owns it during RUN. Writes to a non-existent bank are accepted by the
    // handshake but never reach the array.
    // -----------------------------------------------------------------------
    logic              wr_in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [RGB_W-1:0]  mem_wdata;

    assign wr_in_range = ({1'b0, wr_pal} < PAL_LIMIT);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = KEY_RGB;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_pal, wr_index};
            mem_wdata = wr_rgb;
        end
    end

    logic [RGB_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; its
    // contents are defined by the INIT sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup stage 1: registered RAM read. Reading and writing the same word
    // on one edge returns the old contents (read-before-write).
    // An out-of-range bank reads word 0; its data is ignored in stage 2.
    // -----------------------------------------------------------------------
    logic              pix_in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [RGB_W-1:0]  s1_rgb;
    logic              s1_valid;
    logic              s1_hl;
    logic              s1_oor;

    assign pix_in_range = ({1'b0, pix_pal_i} < PAL_LIMIT);
    assign rd_addr      = pix_in_range ? {pix_pal_i, pix_index_i} : '0;

    always_ff @(posedge clk) begin
        if (pix_valid_i) begin
            s1_rgb <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_hl    <= 1'b0;
            s1_oor   <= 1'b0;
        end else begin
            // Requests during INIT (including its last cycle) are dropped.
            s1_valid <= pix_valid_i && (state == ST_RUN);
            s1_hl    <= pix_hl_i;
            s1_oor   <= !pix_in_range;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup stage 2: colour resolution.
    // The tint halves both the stored and highlight channels before adding,
    // so the sum is at most 2*(2^(COLOR_W-1)-1) and cannot overflow.
    // -----------------------------------------------------------------------
    logic [RGB_W-1:0] tint_rgb;
    logic [RGB_W-1:0] res_rgb;
    logic             res_transp;

    always_comb begin
        tint_rgb = '0;
        for (int c = 0; c < 3; c++) begin
            tint_rgb[c*COLOR_W +: COLOR_W] =
                (s1_rgb[c*COLOR_W +: COLOR_W] >> 1) +
                (HL_RGB[c*COLOR_W +: COLOR_W] >> 1);
        end
    end

    always_comb begin
        res_rgb    = KEY_RGB;
        res_transp = 1'b1;
        // Key hits and missing banks stay transparent; highlight is ignored.
        if (!s1_oor && (s1_rgb != KEY_RGB)) begin
            res_transp = 1'b0;
            res_rgb    = s1_hl ? tint_rgb : s1_rgb;
        end
    end

    // Colour and transparency only update on a valid pixel and otherwise
    // hold; pix_valid_o is their sole qualifier.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_valid_o  <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
            pix_transp_o <= 1'b0;
        end else begin
            pix_valid_o <= s1_valid;
            if (s1_valid) begin
                red          <= res_rgb[2*COLOR_W +: COLOR_W];
                green        <= res_rgb[1*COLOR_W +: COLOR_W];
                blue         <= res_rgb[0*COLOR_W +: COLOR_W];
                pix_transp_o <= res_transp;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_ram.sv
// ---------------------------------------------------------------------------
// tb_sprite_palette_ram
//
// Directed bench for sprite_palette_ram with default parameters
// (16-entry banks, 12 banks, 4-bit channels, key F0F, highlight 0F0).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sprite_palette_ram;

    localparam int INDEX_W = 4;
    localparam int PAL_W   = 4;
    localparam int COLOR_W = 4;
    localparam int DEPTH   = 192;

    logic                 clk;
    logic                 resetn;
    logic                 pix_valid_i;
    logic [PAL_W-1:0]     pix_pal_i;
    logic [INDEX_W-1:0]   pix_index_i;
    logic                 pix_hl_i;
    logic                 pix_valid_o;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 pix_transp_o;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [PAL_W-1:0]     wr_pal;
    logic [INDEX_W-1:0]   wr_index;
    logic [3*COLOR_W-1:0] wr_rgb;
    logic                 init_done;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_palette_ram dut (
        .clk          (clk),
        .resetn       (resetn),
        .pix_valid_i  (pix_valid_i),
        .pix_pal_i    (pix_pal_i),
        .pix_index_i  (pix_index_i),
        .pix_hl_i     (pix_hl_i),
        .pix_valid_o  (pix_valid_o),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .pix_transp_o (pix_transp_o),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_pal       (wr_pal),
        .wr_index     (wr_index),
        .wr_rgb       (wr_rgb),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lookup; returns what the outputs show two edges later.
    task automatic lookup(input logic [PAL_W-1:0] pal, input logic [INDEX_W-1:0] idx,
                          input logic hl, output logic v, output logic [11:0] rgb,
                          output logic t);
        pix_valid_i = 1'b1;
        pix_pal_i   = pal;
        pix_index_i = idx;
        pix_hl_i    = hl;
        tick();
        pix_valid_i = 1'b0;
        pix_hl_i    = 1'b0;
        tick();
        v   = pix_valid_o;
        rgb = {red, green, blue};
        t   = pix_transp_o;
    endtask

    // One-cycle write; returns wr_ready as seen during the request cycle.
    task automatic write(input logic [PAL_W-1:0] pal, input logic [INDEX_W-1:0] idx,
                         input logic [11:0] rgb, output logic rdy);
        wr_valid = 1'b1;
        wr_pal   = pal;
        wr_index = idx;
        wr_rgb   = rgb;
        rdy      = wr_ready;
        tick();
        wr_valid = 1'b0;
    endtask

    function automatic logic [11:0] stream_rgb(input int i);
        logic [3:0] a;
        a = 4'(i);
        return {a, a + 4'd1, 4'hA};
    endfunction

    task automatic test_reset();
        logic saw_valid;
        n_checks++;
        if ({pix_valid_o, red, green, blue, pix_transp_o, wr_ready, init_done} !== 17'd0)
            $display("FAIL reset_outputs: got v=%b rgb=%h%h%h t=%b rdy=%b done=%b, want all 0",
                     pix_valid_o, red, green, blue, pix_transp_o, wr_ready, init_done);
        else n_pass++;

        // Release reset and keep requesting through the whole clear sweep.
        resetn      = 1'b1;
        pix_valid_i = 1'b1;
        pix_pal_i   = 4'd0;
        pix_index_i = 4'd5;
        saw_valid   = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            if (pix_valid_o) saw_valid = 1'b1;
        end
        n_checks++;
        if (init_done !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL init_not_early: after 191 edges done=%b rdy=%b, want 0 0", init_done, wr_ready);
        else n_pass++;

        tick();  // edge 192: last INIT cycle, request still high
        pix_valid_i = 1'b0;
        n_checks++;
        if (init_done !== 1'b1 || wr_ready !== 1'b1)
            $display("FAIL init_done_192: done=%b rdy=%b, want 1 1", init_done, wr_ready);
        else n_pass++;

        tick();
        if (pix_valid_o) saw_valid = 1'b1;
        tick();
        if (pix_valid_o) saw_valid = 1'b1;
        n_checks++;
        if (saw_valid !== 1'b0)
            $display("FAIL init_requests_dropped: pix_valid_o seen %b, want 0", saw_valid);
        else n_pass++;
    endtask

    task automatic test_cleared_lookup();
        logic v, t;
        logic [11:0] rgb;
        lookup(4'd0, 4'd5, 1'b0, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL cleared_entry: got v=%b rgb=%h t=%b, want 1 f0f 1", v, rgb, t);
        else n_pass++;
    endtask

    task automatic test_write_lookup();
        logic v, t, rdy;
        logic [11:0] rgb;
        write(4'd3, 4'd2, 12'hC84, rdy);
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL write_ready: got %b, want 1", rdy);
        else n_pass++;

        lookup(4'd3, 4'd2, 1'b0, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hC84, 1'b0})
            $display("FAIL plain_lookup: got v=%b rgb=%h t=%b, want 1 c84 0", v, rgb, t);
        else n_pass++;

        lookup(4'd3, 4'd2, 1'b1, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'h6B2, 1'b0})
            $display("FAIL highlight: got v=%b rgb=%h t=%b, want 1 6b2 0", v, rgb, t);
        else n_pass++;

        // Idle cycle: valid drops, colour and transparency hold.
        tick();
        n_checks++;
        if ({pix_valid_o, red, green, blue, pix_transp_o} !== {1'b0, 12'h6B2, 1'b0})
            $display("FAIL idle_hold: got v=%b rgb=%h%h%h t=%b, want 0 6b2 0",
                     pix_valid_o, red, green, blue, pix_transp_o);
        else n_pass++;

        lookup(4'd0, 4'd5, 1'b1, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL key_ignores_hl: got v=%b rgb=%h t=%b, want 1 f0f 1", v, rgb, t);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        // Write and lookup of pal1/idx1 share one edge; lookup repeats next cycle.
        wr_valid    = 1'b1;
        wr_pal      = 4'd1;
        wr_index    = 4'd1;
        wr_rgb      = 12'h333;
        pix_valid_i = 1'b1;
        pix_pal_i   = 4'd1;
        pix_index_i = 4'd1;
        pix_hl_i    = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick();
        pix_valid_i = 1'b0;
        n_checks++;
        if ({pix_valid_o, red, green, blue, pix_transp_o} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL rbw_old_value: got v=%b rgb=%h%h%h t=%b, want 1 f0f 1",
                     pix_valid_o, red, green, blue, pix_transp_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({pix_valid_o, red, green, blue, pix_transp_o} !== {1'b1, 12'h333, 1'b0})
            $display("FAIL rbw_new_value: got v=%b rgb=%h%h%h t=%b, want 1 333 0",
                     pix_valid_o, red, green, blue, pix_transp_o);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic v, t, rdy;
        logic [11:0] rgb;
        lookup(4'd12, 4'd0, 1'b1, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL oor_lookup: got v=%b rgb=%h t=%b, want 1 f0f 1", v, rgb, t);
        else n_pass++;

        write(4'd13, 4'd2, 12'h123, rdy);
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL oor_write_ready: got %b, want 1", rdy);
        else n_pass++;

        lookup(4'd3, 4'd2, 1'b0, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hC84, 1'b0})
            $display("FAIL oor_write_p3i2: got v=%b rgb=%h t=%b, want 1 c84 0", v, rgb, t);
        else n_pass++;

        lookup(4'd0, 4'd2, 1'b0, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL oor_write_p0i2: got v=%b rgb=%h t=%b, want 1 f0f 1", v, rgb, t);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic rdy;
        int   bad;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_pal   = 4'd3;
            wr_index = 4'(i);
            wr_rgb   = stream_rgb(i);
            tick();
        end
        wr_valid = 1'b0;
        rdy = 1'b0;

        bad = 0;
        for (int k = 0; k <= 16; k++) begin
            pix_valid_i = (k < 16);
            pix_pal_i   = 4'd3;
            pix_index_i = 4'(k);
            pix_hl_i    = 1'b0;
            tick();
            if (k >= 1) begin
                n_checks++;
                if ({pix_valid_o, red, green, blue, pix_transp_o} !== {1'b1, stream_rgb(k - 1), 1'b0}) begin
                    $display("FAIL stream_%0d: got v=%b rgb=%h%h%h t=%b, want 1 %h 0", k - 1,
                             pix_valid_o, red, green, blue, pix_transp_o, stream_rgb(k - 1));
                    bad++;
                end else n_pass++;
            end
        end
        tick();
        n_checks++;
        if (pix_valid_o !== 1'b0) $display("FAIL stream_end: got v=%b, want 0", pix_valid_o);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic v, t;
        logic [11:0] rgb;
        pix_pal_i   = 4'd3;
        pix_index_i = 4'd2;
        pix_hl_i    = 1'b0;
        pix_valid_i = 1'b1;
        tick();
        tick();
        // Third request being driven, two more already in the pipe.
        n_checks++;
        if (pix_valid_o !== 1'b1) $display("FAIL midrst_inflight: got v=%b, want 1", pix_valid_o);
        else n_pass++;
        #2;
        resetn      = 1'b0;
        pix_valid_i = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid_o, red, green, blue, pix_transp_o, wr_ready, init_done} !== 17'd0)
            $display("FAIL midrst_clear: got v=%b rgb=%h%h%h t=%b rdy=%b done=%b, want all 0",
                     pix_valid_o, red, green, blue, pix_transp_o, wr_ready, init_done);
        else n_pass++;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        n_checks++;
        if (init_done !== 1'b1) $display("FAIL midrst_reinit: got done=%b, want 1", init_done);
        else n_pass++;

        lookup(4'd3, 4'd2, 1'b0, v, rgb, t);
        n_checks++;
        if ({v, rgb, t} !== {1'b1, 12'hF0F, 1'b1})
            $display("FAIL midrst_recleared: got v=%b rgb=%h t=%b, want 1 f0f 1", v, rgb, t);
        else n_pass++;
    endtask

    initial begin
        resetn      = 1'b0;
        pix_valid_i = 1'b0;
        pix_pal_i   = '0;
        pix_index_i = '0;
        pix_hl_i    = 1'b0;
        wr_valid    = 1'b0;
        wr_pal      = '0;
        wr_index    = '0;
        wr_rgb      = '0;
        tick();
        tick();

        test_reset();
        test_cleared_lookup();
        test_write_lookup();
        test_back_to_back();
        test_out_of_range();
        test_streaming();
        test_mid_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_palette_ram.md
# sprite_palette_ram

Runtime-writable, multi-bank colour palette for the HDMI piece renderer. It replaces the per-piece constant palette lookups with one RAM that holds NUM_PALETTES banks of 2^INDEX_W RGB entries. Each pixel gets a 2-cycle pipelined lookup with colour-key transparency detection and an optional highlight tint for the selected square. It sits between the sprite-index ROM readout and the board compositor; a host-side write port reloads colours at run time.

## Interface
Parameters:
- INDEX_W, 4, palette index width; bank depth 2^INDEX_W
- NUM_PALETTES, 12, number of banks (6 pieces x 2 colours)
- COLOR_W, 4, bits per channel
- KEY_RGB, 12'hF0F, transparent colour key {r,g,b}; also the init fill value
- HL_RGB, 12'h0F0, highlight tint colour
- PAL_W, $clog2(NUM_PALETTES), bank-select width (derived)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- pix_valid_i  in  1  lookup request this cycle
- pix_pal_i  in  PAL_W  bank select
- pix_index_i  in  INDEX_W  palette index
- pix_hl_i  in  1  apply highlight tint
- pix_valid_o  out  1  output pixel valid
- red, green, blue  out  COLOR_W each  resolved colour
- pix_transp_o  out  1  stored entry equals KEY_RGB, or bank is out of range
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_pal  in  PAL_W  target bank
- wr_index  in  INDEX_W  target entry
- wr_rgb  in  3*COLOR_W  colour {r,g,b}
- init_done  out  1  high once memory clear is complete

## Operation
- Storage: DEPTH = NUM_PALETTES * 2^INDEX_W words of 3*COLOR_W bits. Address = pal * 2^INDEX_W + index.
- FSM states:
  - INIT is entered on reset. A counter writes KEY_RGB to addresses 0..DEPTH-1, one per cycle. In this state wr_ready=0, init_done=0, and pix_valid_o is forced 0.
  - After address DEPTH-1 is written, the FSM moves to RUN. In RUN, wr_ready=1 and init_done=1.
  - RUN is left only through reset.
- Write port:
  - Always ready in RUN. There is no internal buffering.
  - A write with wr_pal >= NUM_PALETTES completes the handshake and is discarded.
- Lookup stage 1 registers the RAM read data together with valid, hl and an out-of-range flag (pix_pal_i >= NUM_PALETTES).
- Lookup stage 2 resolves the colour and registers the outputs:
  - Out-of-range bank: output KEY_RGB with pix_transp_o=1.
  - Stored value == KEY_RGB: output KEY_RGB with pix_transp_o=1. Highlight is ignored.
  - Otherwise, if hl=1, each channel = (c >> 1) + (HL_c >> 1). This cannot overflow COLOR_W. If hl=0, the stored colour passes through unchanged.
- When pix_valid_o=0, the colour outputs hold their last value and pix_transp_o holds its last value. Only pix_valid_o qualifies them.
- Read/write to the same address in the same cycle is read-before-write: the lookup returns the old value, and the next lookup returns the new value.

## Timing
- Reset values: pix_valid_o=0, red=green=blue=0, pix_transp_o=0, wr_ready=0, init_done=0, FSM=INIT, init counter=0.
- Init takes exactly DEPTH cycles after the first clk edge with resetn high. With defaults that is 192, so init_done rises on the 192nd edge.
- Lookup latency is 2 cycles. A request at edge N appears on the outputs after edge N+2. Throughput is 1 lookup per cycle with no pixel backpressure.
- Write latency is 1 cycle. A write accepted at edge N is visible to a lookup issued at edge N+1.
- Reset asserted mid-operation: all pipeline valids clear immediately, the FSM returns to INIT, and the RAM is re-cleared in full. In-flight pixels and writes are dropped.
- Requests issued during INIT are discarded. A request in the last INIT cycle also produces no valid output.

## Test plan
- Reset release: after 192 cycles init_done=1 and wr_ready=1. A lookup of pal 0 / index 5 then gives F,0,F with pix_transp_o=1 two cycles later.
- Write pal 3 / index 2 = 12'hC84, then look it up: output C,8,4 with transp=0 at +2. The same lookup with hl=1 gives 6,B,2 (6+0, 4+7, 2+0).
- Back-to-back: a write to pal 1 / index 1 = 12'h333 in the same cycle as a lookup of that entry returns F0F (old value). A lookup on the next cycle returns 3,3,3.
- Out of range: a lookup with pal 12 returns F0F with transp=1. A write to pal 13 is accepted and no in-range entry changes.
- Streaming: 16 consecutive lookups of pal 3, indices 0..15, give 16 consecutive pix_valid_o cycles in order with no gaps.
- Mid-run reset: assert resetn=0 while 3 lookups are in flight. pix_valid_o drops immediately. After re-init, pal 3 / index 2 reads back F0F.
